// File: rtl/csa_accumulator.sv
// Carry-save multi-operand accumulator: one CSA row per operand, one resolve add per packet.
// Optional operand counter and out_count port enabled by defining CSA_ACC_COUNT_EN.
module csa_accumulator #(
    parameter int WIDTH = 8,
    parameter int ACC_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef CSA_ACC_COUNT_EN
    output logic [7:0]       out_count,
`endif
    output logic [ACC_W-1:0] out_data
);

    // state      | meaning
    // ST_ACC     | accepting operands into the sum/carry pair
    // ST_RESOLVE | single carry-propagate add into res_q
    // ST_OUT     | result presented, waiting for out_ready
    typedef enum logic [1:0] {ST_ACC, ST_RESOLVE, ST_OUT} state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [ACC_W-1:0] car_q, car_d;
    logic [ACC_W-1:0] res_q, res_d;
    logic [ACC_W-1:0] x_ext, cs;
    logic             accept, out_hs;

`ifdef CSA_ACC_COUNT_EN
    logic [7:0] cnt_q, cnt_d;
`endif

    assign x_ext  = ACC_W'(in_data);
    assign cs     = car_q << 1;
    assign accept = in_valid && in_ready;
    assign out_hs = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_ACC;
            sum_q   <= '0;
            car_q   <= '0;
            res_q   <= '0;
`ifdef CSA_ACC_COUNT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            car_q   <= car_d;
            res_q   <= res_d;
`ifdef CSA_ACC_COUNT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACC:     if (accept && in_last) state_d = ST_RESOLVE;
            ST_RESOLVE: state_d = ST_OUT;
            ST_OUT:     if (out_ready) state_d = ST_ACC;
            default:    state_d = ST_ACC;
        endcase
        if (flush) state_d = ST_ACC;
    end

    // Datapath; the carry out of the top bit is dropped by the ACC_W-wide shift.
    always_comb begin
        sum_d = sum_q;
        car_d = car_q;
        res_d = res_q;
`ifdef CSA_ACC_COUNT_EN
        cnt_d = cnt_q;
`endif
        if (flush) begin
            sum_d = '0;
            car_d = '0;
            res_d = '0;
`ifdef CSA_ACC_COUNT_EN
            cnt_d = '0;
`endif
        end else begin
            if (accept) begin
                sum_d = sum_q ^ cs ^ x_ext;
                car_d = (sum_q & cs) | (sum_q & x_ext) | (cs & x_ext);
`ifdef CSA_ACC_COUNT_EN
                if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
`endif
            end
            if (state_q == ST_RESOLVE) res_d = sum_q + cs;
            if (out_hs) begin
                sum_d = '0;
                car_d = '0;
`ifdef CSA_ACC_COUNT_EN
                cnt_d = '0;
`endif
            end
        end
    end

    always_comb begin
        in_ready  = (state_q == ST_ACC) && !flush;
        out_valid = (state_q == ST_OUT);
        out_data  = out_valid ? res_q : '0;
`ifdef CSA_ACC_COUNT_EN
        out_count = out_valid ? cnt_q : 8'd0;
`endif
    end

endmodule

// File: tb/tb_csa_accumulator.sv
// Directed self-checking bench for csa_accumulator (default WIDTH=8, ACC_W=12).
// Count checks are active when CSA_ACC_COUNT_EN is defined.
module tb_csa_accumulator;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_last, out_ready;
    logic        in_ready, out_valid;
    logic [7:0]  in_data;
    logic [11:0] out_data;
`ifdef CSA_ACC_COUNT_EN
    logic [7:0]  out_count;
`endif

    int checks = 0;
    int failures = 0;

    csa_accumulator #(.WIDTH(8), .ACC_W(12)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef CSA_ACC_COUNT_EN
        .out_count (out_count),
`endif
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one operand for exactly one edge; in_ready must be high going in.
    task automatic push(input logic [7:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_count(input string tag, input int exp);
`ifdef CSA_ACC_COUNT_EN
        check(tag, 32'(out_count), 32'(exp));
`endif
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_data = 8'h00; out_ready = 1'b0;

        // Reset then idle
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check_count("rst_out_count", 0);

        // Back-to-back 16 x 0xFF
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) push(8'hFF, i == 15);
        check("b2b_resolve_ready", 32'(in_ready), 0);
        check("b2b_resolve_valid", 32'(out_valid), 0);
        check("b2b_resolve_data", 32'(out_data), 0);
        tick();
        check("b2b_valid", 32'(out_valid), 1);
        check("b2b_data", 32'(out_data), 32'h0FF0);
        check_count("b2b_count", 16);
        tick();
        check("b2b_consumed", 32'(out_valid), 0);
        check("b2b_ready_again", 32'(in_ready), 1);

        // Single operand
        push(8'h5A, 1'b1);
        check("single_resolve_ready", 32'(in_ready), 0);
        tick();
        check("single_out_ready", 32'(in_ready), 0);
        check("single_valid", 32'(out_valid), 1);
        check("single_data", 32'(out_data), 32'h05A);
        check_count("single_count", 1);
        tick();

        // Backpressure plus wrap: 20 x 0xFF = 0x13EC -> 0x3EC
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) push(8'hFF, i == 19);
        tick();
        in_valid = 1'b1;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = (i % 2 == 0) ? 8'hA5 : 8'h5A;
            check("bp_valid", 32'(out_valid), 1);
            check("bp_data", 32'(out_data), 32'h3EC);
            check("bp_in_ready", 32'(in_ready), 0);
            tick();
        end
        check_count("bp_count", 20);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_consumed", 32'(out_valid), 0);
        check("bp_data_zero", 32'(out_data), 0);

        // Flush mid-packet
        push(8'h10, 1'b0);
        push(8'h20, 1'b0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h40;
        #1;
        check("flush_in_ready", 32'(in_ready), 0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        push(8'h03, 1'b0);
        push(8'h04, 1'b1);
        tick();
        check("flush_valid", 32'(out_valid), 1);
        check("flush_data", 32'(out_data), 32'h007);
        check_count("flush_count", 2);
        tick();

        // Reset mid-OUT
        out_ready = 1'b0;
        push(8'h22, 1'b1);
        tick();
        check("rstout_pre_valid", 32'(out_valid), 1);
        check("rstout_pre_data", 32'(out_data), 32'h022);
        rst_n = 1'b0;
        tick();
        check("rstout_valid", 32'(out_valid), 0);
        check("rstout_data", 32'(out_data), 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        check("rstout_in_ready", 32'(in_ready), 1);
        push(8'h01, 1'b1);
        tick();
        check("rstout_next_valid", 32'(out_valid), 1);
        check("rstout_next_data", 32'(out_data), 32'h001);
        check_count("rstout_next_count", 1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/csa_accumulator.md
# csa_accumulator

Sequential multi-operand adder. Accepts a stream of WIDTH-bit operands over a valid/ready handshake and reduces each one into a redundant sum/carry register pair with one carry-save stage per operand. On the last operand it performs a single carry-propagate resolve and presents the ACC_W-bit total on a valid/ready output port. It sequences the carry-save datapath so that a packet of any length reuses one row of full adders.

## Interface

- WIDTH, 8: operand width in bits; minimum 1.
- ACC_W, 12: accumulator and result width in bits; must be at least WIDTH.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- flush  input  1  synchronous abort; discards the packet in progress.
- in_valid  input  1  an operand is offered.
- in_ready  output  1  the block can accept an operand.
- in_data  input  WIDTH  operand, unsigned, zero-extended to ACC_W.
- in_last  input  1  qualifies in_data as the final operand of the packet.
- out_valid  output  1  result is available.
- out_ready  input  1  the consumer accepts the result.
- out_data  output  ACC_W  packet sum modulo 2^ACC_W.
- out_count  output  8  number of operands in the packet; present only with CSA_ACC_COUNT_EN.

## Operation

- Internal state: sum_r[ACC_W], car_r[ACC_W], res_r[ACC_W], and a state machine with states ACC, RESOLVE and OUT.
- Accept: a transfer occurs on a rising edge where in_valid and in_ready are both 1.
- ACC state:
  - in_ready = 1.
  - On each accept, with x = zero-extended in_data and cs = car_r << 1 (truncated to ACC_W):
    - sum_r <= sum_r ^ cs ^ x
    - car_r <= majority(sum_r, cs, x), bitwise
  - The carry out of bit ACC_W-1 is discarded.
  - An accept with in_last = 1 performs the same update and then moves to RESOLVE.
- RESOLVE state:
  - in_ready = 0.
  - Exactly one cycle: res_r <= sum_r + (car_r << 1), modulo 2^ACC_W.
  - Next state is OUT.
- OUT state:
  - out_valid = 1; out_data = res_r, held stable.
  - in_ready = 0.
  - On out_valid && out_ready: sum_r and car_r clear to 0 and the state returns to ACC.
- Single-operand packet (first accept has in_last = 1) is legal; the result equals that operand.
- Inputs are ignored whenever in_ready = 0, including in_last.
- flush = 1, in any state:
  - Next state is ACC; sum_r, car_r and res_r clear to 0; out_valid drops next cycle.
  - An operand presented in the same cycle is not accepted: in_ready is forced to 0 while flush = 1.
  - An output handshake in the same cycle still counts as consumed.
- out_data is 0 whenever out_valid = 0.
- Priority: rst_n low, then flush, then handshakes.

## Timing

- Reset (rst_n = 0 at an edge):
  - State goes to ACC; sum_r, car_r and res_r go to 0.
  - out_valid = 0, out_data = 0, out_count = 0.
  - in_ready = 1 from the first cycle after reset releases.
  - Reset mid-packet or mid-OUT abandons the packet silently.
- Throughput in ACC: one operand per cycle.
- Latency: last operand accepted at edge N; RESOLVE occupies the cycle after edge N; res_r is loaded at edge N+1; out_valid = 1 from edge N+1.
- Earliest next accept: the edge after the output handshake edge. Minimum packet period is the operand count plus 2 cycles.
- Backpressure: OUT is held indefinitely with out_data stable until out_ready.
- Overflow: the sum wraps modulo 2^ACC_W. No flag is raised.

## Configuration

- CSA_ACC_COUNT_EN defined:
  - Adds an 8-bit operand counter, incremented on every accept.
  - The counter saturates at 255 and clears whenever sum_r and car_r clear.
  - The out_count port exists; it equals the counter in OUT and is 0 otherwise.
- CSA_ACC_COUNT_EN undefined: no counter and no out_count port. All other behaviour is identical.

## Test plan

- Reset then idle: rst_n = 0 for 2 cycles -> in_ready = 1, out_valid = 0, out_data = 0 after release.
- Back-to-back stream: 16 operands of 0xFF, one per cycle, last flagged, out_ready = 1 -> out_data = 0xFF0 exactly 1 cycle after the last accept edge; out_count = 16 with the macro.
- Single operand: 0x5A with in_last = 1 -> out_data = 0x05A; in_ready = 0 for the RESOLVE and OUT cycles.
- Backpressure plus wrap: 20 operands of 0xFF, out_ready held 0 for 5 cycles -> out_data = 0x3EC (0x13EC mod 2^12), held stable for all 5 cycles; in_data toggling during that time has no effect.
- Flush mid-packet: accept 0x10 and 0x20, pulse flush with in_valid = 1, then send the packet 0x03, 0x04 (last) -> out_data = 0x007; the operand offered during flush is not accepted.
- Reset mid-OUT: rst_n low while out_valid = 1 -> out_valid = 0 next cycle; the following packet 0x01 (last) yields out_data = 0x001.
